// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: command FIFO in front of structural_alu. Pops one command
// at a time, drives registered operands into the ALU, waits for the ALU's
// registered result and returns it with the command tag on a valid/ready
// response stream.
module alu_cmd_issuer #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  // command stream
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [2:0]                 cmd_opcode,
  input  logic [15:0]                cmd_a,
  input  logic [15:0]                cmd_b,
  input  logic [TAG_W-1:0]           cmd_tag,
  // ALU side
  output logic [15:0]                alu_inputA,
  output logic [15:0]                alu_inputB,
  output logic [2:0]                 alu_opcode,
  input  logic [15:0]                alu_result,
  input  logic                       alu_overflow,
  // response stream
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [15:0]                rsp_result,
  output logic                       rsp_overflow,
  output logic                       rsp_illegal,
  output logic [TAG_W-1:0]           rsp_tag,
  // status
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] cmd_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic [2:0]       op;
    logic [15:0]      a;
    logic [15:0]      b;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------
  cmd_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push;
  logic             pop;
  logic             fifo_empty;
  cmd_t             cmd_in;
  cmd_t             head;

  // Fullness uses the registered count only, so a pop in the same cycle
  // never makes room for a push.
  assign cmd_ready  = rst_n & (count_q != CNT_W'(DEPTH));
  assign push       = cmd_valid & cmd_ready;
  assign fifo_empty = (count_q == '0);
  assign cmd_count  = count_q;

  assign cmd_in.op  = cmd_opcode;
  assign cmd_in.a   = cmd_a;
  assign cmd_in.b   = cmd_b;
  assign cmd_in.tag = cmd_tag;
  assign head       = mem_q[rd_ptr_q];

  // Next pointer/occupancy; pointers wrap naturally since DEPTH is a power of two
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= cmd_in;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // ---------------------------------------------------------------------
  // Issue FSM
  // ---------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [15:0]      alu_a_q, alu_a_d;
  logic [15:0]      alu_b_q, alu_b_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic [2:0]       pend_op_q, pend_op_d;
  logic [TAG_W-1:0] pend_tag_q, pend_tag_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [15:0]      rsp_result_q, rsp_result_d;
  logic             rsp_overflow_q, rsp_overflow_d;
  logic             rsp_illegal_q, rsp_illegal_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic             pend_illegal;
  logic             pend_arith;

  // Overflow is only meaningful for ADD/SUB; illegal ops still run through
  // the ALU so latency is uniform, but their result is discarded.
  assign pend_illegal = (pend_op_q[2:1] == 2'b11);
  assign pend_arith   = (pend_op_q == 3'b000) || (pend_op_q == 3'b001);

  // Next-state, pop decision and operand/response loads
  always_comb begin
    state_d        = state_q;
    pop            = 1'b0;
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    alu_op_d       = alu_op_q;
    pend_op_d      = pend_op_q;
    pend_tag_d     = pend_tag_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_result_d   = rsp_result_q;
    rsp_overflow_d = rsp_overflow_q;
    rsp_illegal_d  = rsp_illegal_q;
    rsp_tag_d      = rsp_tag_q;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          alu_a_d    = head.a;
          alu_b_d    = head.b;
          alu_op_d   = head.op;
          pend_op_d  = head.op;
          pend_tag_d = head.tag;
          state_d    = S_ISSUE;
        end
      end
      // operands are stable; the ALU registers its result at the end of this cycle
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        rsp_valid_d    = 1'b1;
        rsp_result_d   = pend_illegal ? 16'h0000 : alu_result;
        rsp_overflow_d = alu_overflow & pend_arith;
        rsp_illegal_d  = pend_illegal;
        rsp_tag_d      = pend_tag_q;
        state_d        = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          // issue the next command on the handshake edge to keep 3 cycles/op
          if (!fifo_empty) begin
            pop        = 1'b1;
            alu_a_d    = head.a;
            alu_b_d    = head.b;
            alu_op_d   = head.op;
            pend_op_d  = head.op;
            pend_tag_d = head.tag;
            state_d    = S_ISSUE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state, ALU operand registers and held response
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_op_q       <= '0;
      pend_op_q      <= '0;
      pend_tag_q     <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_result_q   <= '0;
      rsp_overflow_q <= 1'b0;
      rsp_illegal_q  <= 1'b0;
      rsp_tag_q      <= '0;
    end else begin
      state_q        <= state_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      alu_op_q       <= alu_op_d;
      pend_op_q      <= pend_op_d;
      pend_tag_q     <= pend_tag_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_result_q   <= rsp_result_d;
      rsp_overflow_q <= rsp_overflow_d;
      rsp_illegal_q  <= rsp_illegal_d;
      rsp_tag_q      <= rsp_tag_d;
    end
  end

  assign alu_inputA   = alu_a_q;
  assign alu_inputB   = alu_b_q;
  assign alu_opcode   = alu_op_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_overflow = rsp_overflow_q;
  assign rsp_illegal  = rsp_illegal_q;
  assign rsp_tag      = rsp_tag_q;
  assign busy         = !fifo_empty || (state_q != S_IDLE);

endmodule
